// File: rtl/bure_lsu.sv
// Load/store unit: one data-memory transaction at a time over a req/gnt/rvalid
// handshake, returning the aligned and extended load result to writeback.
module bure_lsu #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic                    i_is_store,
  input  logic [2:0]              i_funct3,
  input  logic [DATA_WIDTH-1:0]   i_addr,
  input  logic [DATA_WIDTH-1:0]   i_store_data,
  output logic                    o_done,
  output logic [DATA_WIDTH-1:0]   o_data,
  output logic                    o_fault,
  output logic                    o_mem_req,
  output logic                    o_mem_we,
  output logic [DATA_WIDTH-1:0]   o_mem_addr,
  output logic [DATA_WIDTH/8-1:0] o_mem_wstrb,
  output logic [DATA_WIDTH-1:0]   o_mem_wdata,
  input  logic                    i_mem_gnt,
  input  logic                    i_mem_rvalid,
  input  logic [DATA_WIDTH-1:0]   i_mem_rdata
);

  localparam int NB = DATA_WIDTH / 8;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  logic [1:0]            state;
  logic                  we_q;
  logic [2:0]            f3_q;
  logic [1:0]            off_q;
  logic                  fault_q;
  logic [DATA_WIDTH-1:0] addr_q;
  logic [NB-1:0]         wstrb_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] data_q;

  logic                  fault_c;
  logic [NB-1:0]         wstrb_c;
  logic [DATA_WIDTH-1:0] wdata_c;
  logic [DATA_WIDTH-1:0] load_c;
  logic [DATA_WIDTH-1:0] byte_shift;
  logic [DATA_WIDTH-1:0] half_shift;

  // Decode of the op presented in IDLE: fault check, strobes and replicated data.
  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    fault_c = 1'b0;
    wstrb_c = '0;
    wdata_c = i_store_data;
    if (i_funct3 == 3'b011 || i_funct3[2:1] == 2'b11 || (i_is_store && i_funct3[2]))
      fault_c = 1'b1;
    if (i_funct3[1:0] == 2'b01 && i_addr[0])
      fault_c = 1'b1;
    if (i_funct3[1:0] == 2'b10 && i_addr[1:0] != 2'b00)
      fault_c = 1'b1;
    case (i_funct3[1:0])
      2'b00: begin
        wstrb_c = NB'(4'b0001 << i_addr[1:0]);
        wdata_c = {4{i_store_data[7:0]}};
      end
      2'b01: begin
        wstrb_c = NB'(4'b0011 << {i_addr[1], 1'b0});
        wdata_c = {2{i_store_data[15:0]}};
      end
      default: begin
        wstrb_c = '1;
        wdata_c = i_store_data;
      end
    endcase
    if (!i_is_store || fault_c)
      wstrb_c = '0;
  end

  // Lane extraction uses the byte offset latched at accept, not the live address.
  always_comb begin
    byte_shift = i_mem_rdata >> {off_q, 3'b000};
    half_shift = i_mem_rdata >> {off_q[1], 4'b0000};
    case (f3_q)
      3'b000:  load_c = {{(DATA_WIDTH-8){byte_shift[7]}}, byte_shift[7:0]};
      3'b001:  load_c = {{(DATA_WIDTH-16){half_shift[15]}}, half_shift[15:0]};
      3'b100:  load_c = {{(DATA_WIDTH-8){1'b0}}, byte_shift[7:0]};
      3'b101:  load_c = {{(DATA_WIDTH-16){1'b0}}, half_shift[15:0]};
      default: load_c = i_mem_rdata;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= '0;
      off_q   <= '0;
      fault_q <= 1'b0;
      addr_q  <= '0;
      wstrb_q <= '0;
      wdata_q <= '0;
      data_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            we_q    <= i_is_store && !fault_c;
            f3_q    <= i_funct3;
            off_q   <= i_addr[1:0];
            fault_q <= fault_c;
            addr_q  <= {i_addr[DATA_WIDTH-1:2], 2'b00};
            wstrb_q <= wstrb_c;
            wdata_q <= wdata_c;
            data_q  <= '0;
            state   <= fault_c ? RESP : REQ;
          end
        end
        REQ: begin
          if (i_mem_gnt)
            state <= we_q ? RESP : WAIT;
        end
        WAIT: begin
          if (i_mem_rvalid) begin
            data_q <= load_c;
            state  <= RESP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_ready     = (state == IDLE);
  assign o_mem_req   = (state == REQ);
  assign o_mem_we    = o_mem_req && we_q;
  assign o_mem_addr  = addr_q;
  assign o_mem_wstrb = wstrb_q;
  assign o_mem_wdata = wdata_q;
  assign o_done      = (state == RESP);
  assign o_fault     = o_done && fault_q;
  assign o_data      = o_done ? data_q : '0;

endmodule

// File: tb/tb_bure_lsu.sv
// Directed bench for bure_lsu: loads, stores, faults, grant stall, back-to-back
// ops and reset in the middle of a load.
module tb_bure_lsu;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_valid;
  logic        o_ready;
  logic        i_is_store;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr;
  logic [31:0] i_store_data;
  logic        o_done;
  logic [31:0] o_data;
  logic        o_fault;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [3:0]  o_mem_wstrb;
  logic [31:0] o_mem_wdata;
  logic        i_mem_gnt;
  logic        i_mem_rvalid;
  logic [31:0] i_mem_rdata;

  int n_pass  = 0;
  int n_total = 0;

  bure_lsu #(.DATA_WIDTH(32)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_is_store   (i_is_store),
    .i_funct3     (i_funct3),
    .i_addr       (i_addr),
    .i_store_data (i_store_data),
    .o_done       (o_done),
    .o_data       (o_data),
    .o_fault      (o_fault),
    .o_mem_req    (o_mem_req),
    .o_mem_we     (o_mem_we),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wstrb  (o_mem_wstrb),
    .o_mem_wdata  (o_mem_wdata),
    .i_mem_gnt    (i_mem_gnt),
    .i_mem_rvalid (i_mem_rvalid),
    .i_mem_rdata  (i_mem_rdata)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Outputs are sampled 1 time unit after the rising edge; inputs change at the same point.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic present(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] sd);
    i_valid      = 1'b1;
    i_is_store   = st;
    i_funct3     = f3;
    i_addr       = a;
    i_store_data = sd;
  endtask

  initial begin
    i_rst_n = 1'b0; i_valid = 1'b0; i_is_store = 1'b0; i_funct3 = 3'b000;
    i_addr = '0; i_store_data = '0; i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0;
    i_mem_rdata = '0;
    #12;
    check("rst_ready", 32'(o_ready), 32'd1);
    check("rst_done",  32'(o_done), 32'd0);
    check("rst_fault", 32'(o_fault), 32'd0);
    check("rst_req",   32'(o_mem_req), 32'd0);
    check("rst_we",    32'(o_mem_we), 32'd0);
    check("rst_data",  o_data, 32'h0);
    check("rst_addr",  o_mem_addr, 32'h0);
    check("rst_wstrb", 32'(o_mem_wstrb), 32'h0);
    check("rst_wdata", o_mem_wdata, 32'h0);
    tick();
    i_rst_n = 1'b1;
    tick();

    // LB 0x1003, gnt with req, rvalid next cycle
    present(1'b0, 3'b000, 32'h0000_1003, 32'h0);
    check("lb_ready_T", 32'(o_ready), 32'd1);
    tick();
    i_valid = 1'b0;
    check("lb_req",   32'(o_mem_req), 32'd1);
    check("lb_addr",  o_mem_addr, 32'h0000_1000);
    check("lb_wstrb", 32'(o_mem_wstrb), 32'h0);
    check("lb_we",    32'(o_mem_we), 32'd0);
    check("lb_ready", 32'(o_ready), 32'd0);
    i_mem_gnt = 1'b1;
    tick();
    i_mem_gnt = 1'b0;
    check("lb_req_drop", 32'(o_mem_req), 32'd0);
    check("lb_done_T2",  32'(o_done), 32'd0);
    i_mem_rvalid = 1'b1; i_mem_rdata = 32'h80FF_1234;
    tick();
    i_mem_rvalid = 1'b0;
    check("lb_done_T3", 32'(o_done), 32'd1);
    check("lb_data",    o_data, 32'hFFFF_FF80);
    check("lb_fault",   32'(o_fault), 32'd0);
    tick();
    check("lb_done_pulse", 32'(o_done), 32'd0);
    check("lb_ready_back", 32'(o_ready), 32'd1);

    // LBU same address and data
    present(1'b0, 3'b100, 32'h0000_1003, 32'h0);
    tick();
    i_valid = 1'b0; i_mem_gnt = 1'b1;
    check("lbu_req", 32'(o_mem_req), 32'd1);
    tick();
    i_mem_gnt = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = 32'h80FF_1234;
    tick();
    i_mem_rvalid = 1'b0;
    check("lbu_done", 32'(o_done), 32'd1);
    check("lbu_data", o_data, 32'h0000_0080);
    tick();

    // SH 0x2002
    present(1'b1, 3'b001, 32'h0000_2002, 32'h1234_ABCD);
    tick();
    i_valid = 1'b0;
    check("sh_req",   32'(o_mem_req), 32'd1);
    check("sh_we",    32'(o_mem_we), 32'd1);
    check("sh_addr",  o_mem_addr, 32'h0000_2000);
    check("sh_wstrb", 32'(o_mem_wstrb), 32'hC);
    check("sh_wdata", o_mem_wdata, 32'hABCD_ABCD);
    i_mem_gnt = 1'b1;
    tick();
    i_mem_gnt = 1'b0;
    check("sh_done",  32'(o_done), 32'd1);
    check("sh_data",  o_data, 32'h0);
    check("sh_fault", 32'(o_fault), 32'd0);
    check("sh_req_drop", 32'(o_mem_req), 32'd0);
    tick();

    // Misaligned LW 0x3001 and SH 0x3003
    present(1'b0, 3'b010, 32'h0000_3001, 32'h0);
    tick();
    i_valid = 1'b0;
    check("lw_mis_req",   32'(o_mem_req), 32'd0);
    check("lw_mis_done",  32'(o_done), 32'd1);
    check("lw_mis_fault", 32'(o_fault), 32'd1);
    check("lw_mis_data",  o_data, 32'h0);
    tick();
    check("lw_mis_fault_clr", 32'(o_fault), 32'd0);
    check("lw_mis_req2",      32'(o_mem_req), 32'd0);
    present(1'b1, 3'b001, 32'h0000_3003, 32'h5555_AAAA);
    tick();
    i_valid = 1'b0;
    check("sh_mis_req",   32'(o_mem_req), 32'd0);
    check("sh_mis_done",  32'(o_done), 32'd1);
    check("sh_mis_fault", 32'(o_fault), 32'd1);
    check("sh_mis_data",  o_data, 32'h0);
    tick();

    // Stray rvalid while idle
    i_mem_rvalid = 1'b1; i_mem_rdata = 32'hFFFF_FFFF;
    tick();
    i_mem_rvalid = 1'b0;
    check("stray_done",  32'(o_done), 32'd0);
    check("stray_ready", 32'(o_ready), 32'd1);

    // SW 0x4000 with grant withheld 3 cycles
    present(1'b1, 3'b010, 32'h0000_4000, 32'hDEAD_BEEF);
    tick();
    i_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) i_mem_gnt = 1'b1;
      check($sformatf("sw_stall_req%0d", i),   32'(o_mem_req), 32'd1);
      check($sformatf("sw_stall_addr%0d", i),  o_mem_addr, 32'h0000_4000);
      check($sformatf("sw_stall_wdata%0d", i), o_mem_wdata, 32'hDEAD_BEEF);
      check($sformatf("sw_stall_wstrb%0d", i), 32'(o_mem_wstrb), 32'hF);
      check($sformatf("sw_stall_ready%0d", i), 32'(o_ready), 32'd0);
      check($sformatf("sw_stall_done%0d", i),  32'(o_done), 32'd0);
      if (i < 3) tick();
    end
    tick();
    i_mem_gnt = 1'b0;
    check("sw_done",     32'(o_done), 32'd1);
    check("sw_req_drop", 32'(o_mem_req), 32'd0);
    tick();

    // Back-to-back: LW 0x5000, then LHU 0x5002 with i_valid held high
    present(1'b0, 3'b010, 32'h0000_5000, 32'h0);
    tick();
    present(1'b0, 3'b101, 32'h0000_5002, 32'h0);
    check("b2b_lw_req",   32'(o_mem_req), 32'd1);
    check("b2b_lw_ready", 32'(o_ready), 32'd0);
    i_mem_gnt = 1'b1;
    tick();
    i_mem_gnt = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = 32'h1234_5678;
    check("b2b_wait_ready", 32'(o_ready), 32'd0);
    tick();
    i_mem_rvalid = 1'b0;
    check("b2b_lw_done",  32'(o_done), 32'd1);
    check("b2b_lw_data",  o_data, 32'h1234_5678);
    check("b2b_resp_ready", 32'(o_ready), 32'd0);
    tick();
    check("b2b_ready_back", 32'(o_ready), 32'd1);
    tick();
    i_valid = 1'b0;
    check("b2b_lhu_req",  32'(o_mem_req), 32'd1);
    check("b2b_lhu_addr", o_mem_addr, 32'h0000_5000);
    i_mem_gnt = 1'b1;
    tick();
    i_mem_gnt = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = 32'hBEEF_0000;
    tick();
    i_mem_rvalid = 1'b0;
    check("b2b_lhu_done", 32'(o_done), 32'd1);
    check("b2b_lhu_data", o_data, 32'h0000_BEEF);
    tick();

    // Reset while waiting for load data
    present(1'b0, 3'b010, 32'h0000_6000, 32'h0);
    tick();
    i_valid = 1'b0; i_mem_gnt = 1'b1;
    tick();
    i_mem_gnt = 1'b0;
    check("rstw_ready_before", 32'(o_ready), 32'd0);
    i_rst_n = 1'b0;
    #1;
    check("rstw_req",   32'(o_mem_req), 32'd0);
    check("rstw_ready", 32'(o_ready), 32'd1);
    tick();
    i_rst_n = 1'b1;
    i_mem_rvalid = 1'b1; i_mem_rdata = 32'h0BAD_0BAD;
    tick();
    i_mem_rvalid = 1'b0;
    check("rstw_late_rvalid_done", 32'(o_done), 32'd0);
    present(1'b0, 3'b010, 32'h0000_6004, 32'h0);
    tick();
    i_valid = 1'b0;
    check("rstw_next_req",  32'(o_mem_req), 32'd1);
    check("rstw_next_addr", o_mem_addr, 32'h0000_6004);
    i_mem_gnt = 1'b1;
    tick();
    i_mem_gnt = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = 32'hCAFE_F00D;
    tick();
    i_mem_rvalid = 1'b0;
    check("rstw_next_done", 32'(o_done), 32'd1);
    check("rstw_next_data", o_data, 32'hCAFE_F00D);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
